// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character path: writer FSM states,
// command opcodes and ASCII constants (also used by the LCD bus driver).
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DIGIT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ASCII_ZERO        = 8'h30;
    localparam logic [7:0] ASCII_SPACE       = 8'h20;
    localparam logic [7:0] ASCII_QMARK       = 8'h3F;

    localparam int         NUM_DIGITS = 5;
    localparam logic [2:0] LAST_IDX   = 3'd4;

    // "Set DDRAM address" command byte for a 7-bit display address.
    function automatic logic [7:0] ddram_cmd(input logic [6:0] addr);
        return LCD_CMD_SET_DDRAM | {1'b0, addr};
    endfunction

endpackage

// File: rtl/bcd_digit_to_ascii.sv
// Maps one BCD digit to its display character: '?' for non-BCD codes,
// space for a blanked leading zero, otherwise the ASCII numeral.
module bcd_digit_to_ascii
    import lcd_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [7:0] o_byte
);

    // NOTE: every branch of a combinational block must assign every output,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        if (i_digit > 4'd9) begin
            o_byte = ASCII_QMARK;
        end else if (i_blank && (i_digit == 4'd0)) begin
            o_byte = ASCII_SPACE;
        end else begin
            o_byte = ASCII_ZERO + {4'b0000, i_digit};
        end
    end

endmodule

// File: rtl/lcd_number_writer.sv
// Writes a five-digit BCD number to an HD44780 display: one DDRAM address
// command followed by five characters, MSD first, over valid/ready.
module lcd_number_writer
    import lcd_pkg::*;
#(
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] tenThou,
    input  logic [3:0] thou,
    input  logic [3:0] hund,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic [6:0] addr,
    output logic       busy,
    output logic       done,
    output logic       lcd_valid,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    input  logic       lcd_ready
);

    state_t                        r_state;
    state_t                        w_next_state;
    logic [2:0]                    r_idx;
    logic                          r_lead;
    logic [NUM_DIGITS-1:0][3:0]    r_digits;
    logic [6:0]                    r_addr;

    logic                          w_start_accept;
    logic                          w_digit_xfer;
    logic [3:0]                    w_cur_digit;
    logic                          w_blank;
    logic [7:0]                    w_ascii;

    assign w_start_accept = start && (r_state == IDLE);
    assign w_digit_xfer   = (r_state == DIGIT) && lcd_ready;
    assign w_blank        = r_lead && (r_idx != LAST_IDX);

    // r_digits[0] holds the ten-thousands digit, r_digits[4] the ones digit.
    always_comb begin
        w_cur_digit = r_digits[0];
        case (r_idx)
            3'd1:    w_cur_digit = r_digits[1];
            3'd2:    w_cur_digit = r_digits[2];
            3'd3:    w_cur_digit = r_digits[3];
            3'd4:    w_cur_digit = r_digits[4];
            default: w_cur_digit = r_digits[0];
        endcase
    end

    bcd_digit_to_ascii u_digit_to_ascii (
        .i_digit (w_cur_digit),
        .i_blank (w_blank),
        .o_byte  (w_ascii)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs decode from registers only; lcd_ready steers next state, never
    // the byte currently offered.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        lcd_valid    = 1'b0;
        lcd_rs       = 1'b0;
        lcd_data     = 8'h00;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = ADDR;
                end
            end
            ADDR: begin
                lcd_valid = 1'b1;
                lcd_data  = ddram_cmd(r_addr);
                if (lcd_ready) begin
                    w_next_state = DIGIT;
                end
            end
            DIGIT: begin
                lcd_valid = 1'b1;
                lcd_rs    = 1'b1;
                lcd_data  = w_ascii;
                if (lcd_ready && (r_idx == LAST_IDX)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Sequencing state: digit index and the leading-zero blanking flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= 3'd0;
            r_lead <= 1'b0;
        end else if (w_start_accept) begin
            r_idx  <= 3'd0;
            r_lead <= BLANK_ZEROS;
        end else if (w_digit_xfer) begin
            r_idx <= r_idx + 3'd1;
            if (w_cur_digit != 4'd0) begin
                r_lead <= 1'b0;
            end
        end
    end

    // NOTE: the operand holding registers are deliberately not reset; they
    // are only observed in ADDR/DIGIT, which are reachable solely via a
    // start that loads them.
    always_ff @(posedge clk) begin
        if (w_start_accept) begin
            r_digits[0] <= tenThou;
            r_digits[1] <= thou;
            r_digits[2] <= hund;
            r_digits[3] <= tens;
            r_digits[4] <= ones;
            r_addr      <= addr;
        end
    end

endmodule
